// File: rtl/lsu_bus_ctrl.sv
// Multi-cycle load/store unit driving a req/ack memory bus with byte enables.
// Decodes size/sign from funct3, faults on misalignment, illegal size, bus error or timeout.
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        MemRead,
    input  logic        MemWr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        req_q, req_d, we_q, we_d, done_q, done_d, fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
    logic [3:0]  be_q, be_d;

    logic        accept, illegal, misal;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, ext_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;

    assign accept = start & (MemRead | MemWr);
    assign stall  = ~rst & (((state_q == IDLE) & accept) | (state_q == REQ));

    // Stores only define sizes 000..010; loads additionally allow the unsigned 100/101.
    assign illegal = MemWr ? (funct3 > 3'b010) : ((funct3[1:0] == 2'b11) | (funct3 == 3'b110));
    assign misal   = ((funct3[1:0] == 2'b01) & addr[0]) | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = write_data;
        case (funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{write_data[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {addr[1], 1'b0};
                wdata_c = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_c = mem_rdata[7:0];
        case (off_q)
            2'd1:    byte_c = mem_rdata[15:8];
            2'd2:    byte_c = mem_rdata[23:16];
            2'd3:    byte_c = mem_rdata[31:24];
            default: ;
        endcase
        half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  ext_c = {{16{half_c[15]}}, half_c};
            3'b100:  ext_c = {24'd0, byte_c};
            3'b101:  ext_c = {16'd0, half_c};
            default: ext_c = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        ld_d    = ld_q;
        fault_d = fault_q;
        cause_d = cause_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = MemWr;
                    addr_d  = {addr[31:2], 2'b00};
                    be_d    = be_c;
                    wdata_d = wdata_c;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                    ld_d    = 32'd0;
                    if (illegal | misal) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        cause_d = illegal ? 2'b01 : 2'b00;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        cnt_d   = 8'd1;
                    end
                end
            end
            REQ: begin
                if (mem_err) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    cause_d = 2'b10;
                end else if (mem_ack) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    fault_d = 1'b0;
                    if (!we_q) ld_d = ext_c;
                end else if (cnt_q == TimeoutCnt) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    cause_d = 2'b11;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                fault_d = 1'b0;
                cause_d = 2'b00;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            ld_q    <= 32'd0;
            fault_q <= 1'b0;
            cause_q <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ld_q    <= ld_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            done_q  <= done_d;
        end
    end

    assign done        = done_q;
    assign load_data   = ld_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_be      = be_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench: directed vector table, corner sequences and random accesses vs a model.
module tb_lsu_bus_ctrl;

    localparam int Tmo = 16;

    logic        clk = 1'b0;
    logic        rst, start, start4, MemRead, MemWr, mem_ack, mem_err;
    logic [2:0]  funct3;
    logic [31:0] addr, write_data, mem_rdata;
    logic        stall, done, fault, mem_req, mem_we;
    logic [1:0]  fault_cause;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        stall4, done4, fault4, mem_req4, mem_we4;
    logic [1:0]  fault_cause4;
    logic [31:0] load_data4, mem_addr4, mem_wdata4;
    logic [3:0]  mem_be4;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    lsu_bus_ctrl #(.TIMEOUT(Tmo)) u_dut (
        .clk(clk), .rst(rst), .start(start), .MemRead(MemRead), .MemWr(MemWr),
        .funct3(funct3), .addr(addr), .write_data(write_data), .stall(stall), .done(done),
        .load_data(load_data), .fault(fault), .fault_cause(fault_cause), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    lsu_bus_ctrl #(.TIMEOUT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .MemRead(MemRead), .MemWr(MemWr),
        .funct3(funct3), .addr(addr), .write_data(write_data), .stall(stall4), .done(done4),
        .load_data(load_data4), .fault(fault4), .fault_cause(fault_cause4), .mem_req(mem_req4),
        .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_be(mem_be4),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdat;
        int          ack_at;
        int          err_at;
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] ld;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic wr, input logic rd, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdat, input int ack_at, input int err_at,
                                input logic flt, input logic [1:0] cause, input logic [31:0] ld,
                                input logic [3:0] be, input logic [31:0] wdata);
        txn_t t;
        t.wr = wr; t.rd = rd; t.f3 = f3; t.a = a; t.wd = wd; t.rdat = rdat;
        t.ack_at = ack_at; t.err_at = err_at; t.fault = flt; t.cause = cause;
        t.ld = ld; t.be = be; t.wdata = wdata;
        return t;
    endfunction

    // First REQ cycle in which the bus response (or the timeout) ends the access.
    function automatic int bus_end(input txn_t t, input int tmo);
        for (int k = 1; k < tmo; k++)
            if (k == t.err_at || k == t.ack_at) return k;
        return tmo;
    endfunction

    function automatic txn_t model(input txn_t t, input int tmo);
        int nb, off, lane, k;
        logic ill, mis;
        logic [31:0] v, mask;
        nb   = 1 << t.f3[1:0];
        off  = int'(t.a[1:0]);
        ill  = t.wr ? (t.f3 > 3'd2) : (t.f3 == 3'd3 || t.f3 == 3'd6 || t.f3 == 3'd7);
        mis  = !ill && (off % nb != 0);
        lane = (off / nb) * nb;
        t.be = 4'd0; t.wdata = 32'd0; t.ld = 32'd0; t.fault = 1'b0; t.cause = 2'd0;
        if (ill || mis) begin
            t.fault = 1'b1;
            t.cause = ill ? 2'd1 : 2'd0;
            return t;
        end
        t.be = 4'(((1 << nb) - 1) << lane);
        for (int i = 0; i < 4; i++) t.wdata[8*i +: 8] = t.wd[8*(i % nb) +: 8];
        k = bus_end(t, tmo);
        if (k == t.err_at) begin
            t.fault = 1'b1; t.cause = 2'd2;
        end else if (k != t.ack_at) begin
            t.fault = 1'b1; t.cause = 2'd3;
        end
        v = t.rdat >> (8 * lane);
        if (nb < 4) begin
            mask = (32'd1 << (8 * nb)) - 32'd1;
            v    = v & mask;
            if (!t.f3[2] && v[8*nb-1]) v = v | ~mask;
        end
        if (!t.fault && !t.wr) t.ld = v;
        return t;
    endfunction

    task automatic run_txn(input txn_t t);
        int term;
        logic decfault;
        decfault = t.fault && !t.cause[1];
        @(negedge clk);
        start = 1'b1; MemWr = t.wr; MemRead = t.rd; funct3 = t.f3; addr = t.a;
        write_data = t.wd; mem_rdata = t.rdat; mem_ack = 1'b0; mem_err = 1'b0;
        #1 chk("stall_accept", {31'd0, stall}, 32'd1);
        @(negedge clk);
        // Scramble the request inputs so any non-registered path shows up.
        start = 1'b0; MemWr = 1'b0; MemRead = 1'b0; funct3 = ~t.f3; addr = ~t.a;
        write_data = ~t.wd;
        if (!decfault) begin
            term = bus_end(t, Tmo);
            for (int k = 1; k <= term; k++) begin
                if (k > 1) @(negedge clk);
                chk("req", {31'd0, mem_req}, 32'd1);
                chk("done_early", {31'd0, done}, 32'd0);
                chk("addr", mem_addr, {t.a[31:2], 2'b00});
                chk("be", {28'd0, mem_be}, {28'd0, t.be});
                chk("we", {31'd0, mem_we}, {31'd0, t.wr});
                if (t.wr) chk("wdata", mem_wdata, t.wdata);
                mem_ack = (k == t.ack_at);
                mem_err = (k == t.err_at);
                #1 chk("stall_req", {31'd0, stall}, 32'd1);
            end
            @(negedge clk);
            mem_ack = 1'b0; mem_err = 1'b0;
        end
        chk("done", {31'd0, done}, 32'd1);
        chk("fault", {31'd0, fault}, {31'd0, t.fault});
        if (t.fault) chk("cause", {30'd0, fault_cause}, {30'd0, t.cause});
        chk("load_data", load_data, t.ld);
        chk("req_done", {31'd0, mem_req}, 32'd0);
        start = 1'b1; MemRead = 1'b1; funct3 = 3'd2; addr = 32'h0;
        #1 chk("stall_done", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; MemRead = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("req_after", {31'd0, mem_req}, 32'd0);
        chk("load_hold", load_data, t.ld);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        txn_t tbl[$];
        txn_t t;
        int n;
        logic got;

        rst = 1'b1; start = 1'b1; start4 = 1'b0; MemRead = 1'b1; MemWr = 1'b0;
        funct3 = 3'd2; addr = 32'h0; write_data = 32'h0; mem_ack = 1'b0; mem_err = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        #1 chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; MemRead = 1'b0;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_ld", load_data, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);

        //               wr rd f3      addr   wd             rdata          ack err flt cs  ld             be     wdata
        tbl.push_back(mk(0, 1, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1,  0, 0, 0, 32'hDEADBEEF, 4'hF, 32'h0));
        tbl.push_back(mk(0, 1, 3'b000, 32'h13, 32'h0,        32'h80123456, 1,  0, 0, 0, 32'hFFFFFF80, 4'h8, 32'h0));
        tbl.push_back(mk(0, 1, 3'b100, 32'h13, 32'h0,        32'h80123456, 2,  0, 0, 0, 32'h00000080, 4'h8, 32'h0));
        tbl.push_back(mk(0, 1, 3'b001, 32'h12, 32'h0,        32'h80011234, 1,  0, 0, 0, 32'hFFFF8001, 4'hC, 32'h0));
        tbl.push_back(mk(0, 1, 3'b101, 32'h12, 32'h0,        32'h80011234, 1,  0, 0, 0, 32'h00008001, 4'hC, 32'h0));
        tbl.push_back(mk(0, 1, 3'b000, 32'h11, 32'h0,        32'h00007F00, 1,  0, 0, 0, 32'h0000007F, 4'h2, 32'h0));
        tbl.push_back(mk(1, 0, 3'b000, 32'h21, 32'hA5,       32'hFFFFFFFF, 1,  0, 0, 0, 32'h0,        4'h2, 32'hA5A5A5A5));
        tbl.push_back(mk(1, 0, 3'b001, 32'h22, 32'h1234,     32'hFFFFFFFF, 2,  0, 0, 0, 32'h0,        4'hC, 32'h12341234));
        tbl.push_back(mk(1, 1, 3'b010, 32'h50, 32'hCAFEF00D, 32'h0,        1,  0, 0, 0, 32'h0,        4'hF, 32'hCAFEF00D));
        tbl.push_back(mk(0, 1, 3'b010, 32'h02, 32'h0,        32'h0,        1,  0, 1, 0, 32'h0,        4'h0, 32'h0));
        tbl.push_back(mk(0, 1, 3'b011, 32'h40, 32'h0,        32'h0,        1,  0, 1, 1, 32'h0,        4'h0, 32'h0));
        tbl.push_back(mk(1, 0, 3'b001, 32'h23, 32'h0,        32'h0,        1,  0, 1, 0, 32'h0,        4'h0, 32'h0));
        tbl.push_back(mk(1, 0, 3'b011, 32'h44, 32'h0,        32'h0,        1,  0, 1, 1, 32'h0,        4'h0, 32'h0));
        tbl.push_back(mk(0, 1, 3'b010, 32'h30, 32'h0,        32'h11223344, 6,  0, 0, 0, 32'h11223344, 4'hF, 32'h0));
        tbl.push_back(mk(0, 1, 3'b010, 32'h34, 32'h0,        32'h55555555, 0,  2, 1, 2, 32'h0,        4'hF, 32'h0));
        tbl.push_back(mk(0, 1, 3'b010, 32'h38, 32'h0,        32'h66666666, 3,  3, 1, 2, 32'h0,        4'hF, 32'h0));
        tbl.push_back(mk(0, 1, 3'b010, 32'h3C, 32'h0,        32'h5A5A0F0F, 16, 0, 0, 0, 32'h5A5A0F0F, 4'hF, 32'h0));
        tbl.push_back(mk(0, 1, 3'b010, 32'h00, 32'h0,        32'h77777777, 0,  0, 1, 3, 32'h0,        4'hF, 32'h0));
        foreach (tbl[i]) run_txn(tbl[i]);

        // Timeout on the TIMEOUT=4 instance: exactly four REQ cycles, then cause 11.
        @(negedge clk);
        start4 = 1'b1; MemRead = 1'b1; funct3 = 3'd2; addr = 32'h100; mem_ack = 1'b0; mem_err = 1'b0;
        @(negedge clk);
        start4 = 1'b0; MemRead = 1'b0;
        n = 0; got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (mem_req4) n++;
            if (done4) begin
                got = 1'b1;
                chk("tmo4_fault", {31'd0, fault4}, 32'd1);
                chk("tmo4_cause", {30'd0, fault_cause4}, 32'd3);
            end else begin
                @(negedge clk);
            end
        end
        chk("tmo4_req_cycles", n, 32'd4);
        chk("tmo4_done_seen", {31'd0, got}, 32'd1);

        // Reset during the second REQ cycle, then a stray ack while idle.
        @(negedge clk);
        start = 1'b1; MemRead = 1'b1; funct3 = 3'd2; addr = 32'h60;
        @(negedge clk);
        start = 1'b0; MemRead = 1'b0;
        @(negedge clk);
        chk("rreq_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1 chk("rreq_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        chk("rreq_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rreq_no_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("late_ack_req", {31'd0, mem_req}, 32'd0);
        chk("late_ack_done", {31'd0, done}, 32'd0);
        chk("late_ack_ld", load_data, 32'd0);
        mem_ack = 1'b0;
        run_txn(tbl[0]);

        for (int i = 0; i < 60; i++) begin
            t.wr     = 1'($urandom % 2);
            t.rd     = t.wr ? 1'($urandom % 2) : 1'b1;
            t.f3     = 3'($urandom % 8);
            t.a      = $urandom;
            t.wd     = $urandom;
            t.rdat   = $urandom;
            t.ack_at = $urandom_range(0, 5);
            t.err_at = ($urandom % 5 == 0) ? $urandom_range(1, 4) : 0;
            run_txn(model(t, Tmo));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/lsu_bus_ctrl.md
# lsu_bus_ctrl

Multi-cycle load/store unit that sits directly downstream of the ALU and replaces the single-cycle data memory array once the core moves onto a real bus. It accepts a load or store from the execute stage (address from the ALU result, store data from rs2, size from funct3). It drives a req/ack memory bus with byte enables and returns a sign- or zero-extended load result. The core's PC and register write are held via `stall` until the access completes.

## Interface
- `TIMEOUT`, 16: maximum REQ cycles without `mem_ack` before the access is aborted; legal range 1–255.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  execute stage presents a memory instruction; sampled only in IDLE.
- `MemRead`  in  1  load request.
- `MemWr`  in  1  store request; wins if both are high.
- `funct3`  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (loads); 000 sb, 001 sh, 010 sw (stores).
- `addr`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (rs2).
- `stall`  out  1  hold PC and instruction.
- `done`  out  1  one-cycle completion pulse.
- `load_data`  out  32  extended load result, valid when `done`=1 and the access was a non-faulting load.
- `fault`  out  1  access ended abnormally; valid with `done`.
- `fault_cause`  out  2  00 misaligned, 01 illegal funct3, 10 bus error, 11 timeout.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address ({addr[31:2],2'b00}).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_ack`  in  1  bus completion; ignored when `mem_req`=0.
- `mem_rdata`  in  32  read word, valid with `mem_ack`.
- `mem_err`  in  1  bus error; valid with `mem_ack` or alone while `mem_req`=1.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE**
  - Acceptance = `start` & (`MemRead` | `MemWr`).
  - On acceptance, register we, aligned addr, be, wdata, funct3 and addr[1:0].
  - Checks: illegal funct3 (loads 011/110/111; stores anything above 010) gives cause 01. Misalignment (h with addr[0]=1, w with addr[1:0]≠0) gives cause 00.
  - Illegal or misaligned: go to DONE with `fault`=1 and no bus request. Otherwise go to REQ.
- **REQ**
  - `mem_req`=1; all `mem_*` outputs stay stable until exit.
  - Cycle counter starts at 1 on entry.
  - `mem_err`=1 (with or without ack): DONE, cause 10.
  - Else `mem_ack`=1: DONE; for loads, capture the extracted data.
  - Else if counter = `TIMEOUT`: DONE, cause 11.
  - Else counter increments.
- **DONE**: `done`=1 for one cycle, then IDLE. `start` is ignored in DONE.
- **Byte enables**
  - sb: 4'b0001 << addr[1:0].
  - sh: 4'b0011 << {addr[1],1'b0}.
  - sw: 4'b1111.
- **Store data**: sb {4{wd[7:0]}}; sh {2{wd[15:0]}}; sw wd.
- **Load extraction**
  - Select byte lane addr[1:0] or half lane addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- **Faulting accesses**: `load_data`=0 on any fault, and on stores.
- **`load_data` hold**: holds its value until the next acceptance, then clears to 0.
- **`stall`**: `stall` = (IDLE & acceptance) | REQ. It is 0 in DONE so the core advances on the DONE edge.

## Timing
- **Reset**
  - While `rst`=1 at an edge, the next state is IDLE with the counter cleared.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `done`, `fault`, `fault_cause`, `load_data` all reset to 0.
  - `stall` is forced 0 while `rst`=1.
  - Reset in REQ drops `mem_req` after the edge; a late `mem_ack` in IDLE is ignored.
- **Outputs**: all outputs registered except `stall`, which is combinational from state and inputs.
- **Latency**
  - Ack in the first REQ cycle: accept cycle 0 (IDLE, stall=1), REQ cycle 1 (stall=1), DONE cycle 2 (done=1, stall=0).
  - Each extra wait cycle adds 1.
  - Faulting decode: cycle 0 IDLE, cycle 1 DONE.
- **Back-to-back**: a new access is accepted no earlier than the cycle after DONE, giving a minimum 3 cycles per access.
- **Boundary cases**
  - Ack in REQ cycle `TIMEOUT` is a normal completion.
  - Ack and err in the same cycle is reported as a bus error.

## Test plan
- **lw**: addr 0x0000_0010, `mem_rdata`=0xDEAD_BEEF, ack in first REQ cycle -> mem_addr 0x10, be 1111, done in cycle 2, load_data 0xDEAD_BEEF, fault 0, stall high in cycles 0–1 only.
- **lb vs lbu**: addr 0x13, rdata 0x80xx_xxxx -> lb returns 0xFFFF_FF80, lbu returns 0x0000_0080. lh at addr 0x12 with rdata 0x8001_xxxx returns 0xFFFF_8001.
- **sb / sh**
  - sb addr 0x21, wd 0x0000_00A5 -> be 0010, wdata 0xA5A5_A5A5, we 1.
  - sh addr 0x22, wd 0x1234 -> be 1100, wdata 0x1234_1234.
  - Both: load_data 0.
- **Misaligned and illegal**
  - lw addr 0x02 -> no mem_req, done cycle 1, fault 1, cause 00.
  - Load funct3 011 -> cause 01.
- **Wait states and faults**
  - Ack after 5 wait cycles -> done cycle 7, bus signals stable throughout.
  - No ack with `TIMEOUT`=4 -> mem_req high exactly 4 cycles, then done with cause 11.
  - mem_err in cycle 2 of REQ -> cause 10.
- **Reset mid-REQ**: assert rst during cycle 2 of REQ -> mem_req 0 next cycle, state IDLE, no done pulse; a subsequent ack is ignored and a new lw completes normally.
